// File: rtl/alu_share_arb.sv
// Two-port arbiter that time-shares one combinational ALU between two requesters,
// with a one-entry response register per port and per-port backpressure.
module alu_share_arb #(
    parameter int WIDTH      = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [3:0]       req_op_0,
    input  logic [3:0]       req_op_1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             resp_valid_0,
    output logic             resp_valid_1,
    output logic [WIDTH-1:0] resp_data_0,
    output logic [WIDTH-1:0] resp_data_1,
    input  logic             resp_ready_0,
    input  logic             resp_ready_1
);
    localparam logic [3:0] OP_IDLE = 4'b1111;

    logic             w_elig_0;
    logic             w_elig_1;
    logic             w_grant_0;
    logic             w_grant_1;
    logic             r_last_grant;   // index of the most recently granted port
    logic             r_resp_valid_0;
    logic             r_resp_valid_1;
    logic [WIDTH-1:0] r_resp_data_0;
    logic [WIDTH-1:0] r_resp_data_1;

    // A port is eligible if its response slot is free or being drained this cycle.
    always_comb begin
        w_elig_0  = rst_n && req_valid_0 && (!r_resp_valid_0 || resp_ready_0);
        w_elig_1  = rst_n && req_valid_1 && (!r_resp_valid_1 || resp_ready_1);
        w_grant_0 = 1'b0;
        w_grant_1 = 1'b0;
        if (w_elig_0 && w_elig_1) begin
            if ((FIXED_PRIO != 0) || r_last_grant) begin
                w_grant_0 = 1'b1;
            end else begin
                w_grant_1 = 1'b1;
            end
        end else begin
            w_grant_0 = w_elig_0;
            w_grant_1 = w_elig_1;
        end
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_IDLE;
        if (w_grant_0) begin
            alu_a  = req_a_0;
            alu_b  = req_b_0;
            alu_op = req_op_0;
        end else if (w_grant_1) begin
            alu_a  = req_a_1;
            alu_b  = req_b_1;
            alu_op = req_op_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_1) begin
            r_last_grant <= 1'b1;
        end
    end

    // A grant and a drain in the same cycle leave the slot full with the new result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid_0 <= 1'b0;
            r_resp_data_0  <= '0;
        end else if (w_grant_0) begin
            r_resp_valid_0 <= 1'b1;
            r_resp_data_0  <= alu_out;
        end else if (r_resp_valid_0 && resp_ready_0) begin
            r_resp_valid_0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid_1 <= 1'b0;
            r_resp_data_1  <= '0;
        end else if (w_grant_1) begin
            r_resp_valid_1 <= 1'b1;
            r_resp_data_1  <= alu_out;
        end else if (r_resp_valid_1 && resp_ready_1) begin
            r_resp_valid_1 <= 1'b0;
        end
    end

    assign req_ready_0  = w_grant_0;
    assign req_ready_1  = w_grant_1;
    assign resp_valid_0 = r_resp_valid_0;
    assign resp_valid_1 = r_resp_valid_1;
    assign resp_data_0  = r_resp_data_0;
    assign resp_data_1  = r_resp_data_1;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin and a fixed-priority instance
// share the request-side stimulus, each with its own reference ALU.
module tb_alu_share_arb;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid_0, req_valid_1;
    logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [3:0]   req_op_0, req_op_1;
    logic         resp_ready_0, resp_ready_1;

    logic         rr_ready_0, rr_ready_1, rr_rv_0, rr_rv_1;
    logic [W-1:0] rr_alu_a, rr_alu_b, rr_alu_out, rr_rd_0, rr_rd_1;
    logic [3:0]   rr_alu_op;

    logic         fp_ready_0, fp_ready_1, fp_rv_0, fp_rv_1;
    logic [W-1:0] fp_alu_a, fp_alu_b, fp_alu_out, fp_rd_0, fp_rd_1;
    logic [3:0]   fp_alu_op;

    int n_checks;
    int n_fail;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return $unsigned($signed(a) >>> b[4:0]);
            4'd9:    return a >> b[4:0];
            4'd10:   return b;
            default: return '0;
        endcase
    endfunction

    assign rr_alu_out = alu_f(rr_alu_a, rr_alu_b, rr_alu_op);
    assign fp_alu_out = alu_f(fp_alu_a, fp_alu_b, fp_alu_op);

    alu_share_arb #(.WIDTH(W), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(rr_ready_0), .req_ready_1(rr_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op), .alu_out(rr_alu_out),
        .resp_valid_0(rr_rv_0), .resp_valid_1(rr_rv_1),
        .resp_data_0(rr_rd_0), .resp_data_1(rr_rd_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1)
    );

    alu_share_arb #(.WIDTH(W), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(fp_ready_0), .req_ready_1(fp_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op), .alu_out(fp_alu_out),
        .resp_valid_0(fp_rv_0), .resp_valid_1(fp_rv_1),
        .resp_data_0(fp_rd_0), .resp_data_1(fp_rd_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sit 1ns after it for driving and sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req0(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        req_valid_0 = v; req_op_0 = op; req_a_0 = a; req_b_0 = b;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        req_valid_1 = v; req_op_1 = op; req_a_1 = a; req_b_1 = b;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_req0(1'b0, 4'd0, '0, '0);
        set_req1(1'b0, 4'd0, '0, '0);
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        #1;
        step();

        // Request during reset is refused and the ALU stays idle.
        set_req0(1'b1, 4'd0, 32'd9, 32'd9);
        settle();
        chk("rst_ready0", {31'd0, rr_ready_0}, 32'd0);
        chk("rst_alu_op", {28'd0, rr_alu_op}, 32'hF);
        step();
        chk("rst_rv0", {31'd0, rr_rv_0}, 32'd0);
        chk("rst_rd0", rr_rd_0, 32'd0);
        chk("rst_rv1", {31'd0, rr_rv_1}, 32'd0);
        set_req0(1'b0, 4'd0, '0, '0);
        rst_n = 1'b1;

        // Single ADD 5+7 on port 0.
        set_req0(1'b1, 4'd0, 32'd5, 32'd7);
        settle();
        chk("single_ready0", {31'd0, rr_ready_0}, 32'd1);
        chk("single_ready1", {31'd0, rr_ready_1}, 32'd0);
        chk("single_alu_op", {28'd0, rr_alu_op}, 32'd0);
        chk("single_alu_a", rr_alu_a, 32'd5);
        chk("single_alu_b", rr_alu_b, 32'd7);
        step();
        set_req0(1'b0, 4'd0, '0, '0);
        settle();
        chk("single_rv0", {31'd0, rr_rv_0}, 32'd1);
        chk("single_rd0", rr_rd_0, 32'd12);
        resp_ready_0 = 1'b1;
        step();
        chk("drain_rv0", {31'd0, rr_rv_0}, 32'd0);
        chk("drain_rd0_hold", rr_rd_0, 32'd12);

        // Tie after reset: port 0 first, then alternation.
        do_reset();
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;
        set_req0(1'b1, 4'd1, 32'd10, 32'd3);
        set_req1(1'b1, 4'd4, 32'hF0, 32'hFF);
        settle();
        chk("tie_c1_ready0", {31'd0, rr_ready_0}, 32'd1);
        chk("tie_c1_ready1", {31'd0, rr_ready_1}, 32'd0);
        chk("tie_c1_alu_op", {28'd0, rr_alu_op}, 32'd1);
        step();
        set_req0(1'b1, 4'd0, 32'd1, 32'd2);
        settle();
        chk("tie_c2_rv0", {31'd0, rr_rv_0}, 32'd1);
        chk("tie_c2_rd0", rr_rd_0, 32'd7);
        chk("tie_c2_ready0", {31'd0, rr_ready_0}, 32'd0);
        chk("tie_c2_ready1", {31'd0, rr_ready_1}, 32'd1);
        chk("tie_c2_alu_a", rr_alu_a, 32'hF0);
        step();
        set_req1(1'b1, 4'd3, 32'h30, 32'h03);
        settle();
        chk("tie_c3_rv1", {31'd0, rr_rv_1}, 32'd1);
        chk("tie_c3_rd1", rr_rd_1, 32'h0F);
        chk("tie_c3_rv0", {31'd0, rr_rv_0}, 32'd0);
        chk("tie_c3_ready0", {31'd0, rr_ready_0}, 32'd1);
        chk("tie_c3_alu_op", {28'd0, rr_alu_op}, 32'd0);
        step();
        settle();
        chk("tie_c4_rd0", rr_rd_0, 32'd3);
        chk("tie_c4_ready1", {31'd0, rr_ready_1}, 32'd1);
        chk("tie_c4_ready0", {31'd0, rr_ready_0}, 32'd0);
        chk("tie_c4_alu_op", {28'd0, rr_alu_op}, 32'd3);
        resp_ready_0 = 1'b0;
        step();

        // Backpressure: port 0 full and not drained, port 1 granted despite last_grant.
        settle();
        chk("bp_rd1", rr_rd_1, 32'h33);
        chk("bp_rv0", {31'd0, rr_rv_0}, 32'd1);
        chk("bp_rd0", rr_rd_0, 32'd3);
        chk("bp_ready0", {31'd0, rr_ready_0}, 32'd0);
        chk("bp_ready1", {31'd0, rr_ready_1}, 32'd1);
        resp_ready_0 = 1'b1;
        settle();
        chk("bp_drain_ready0", {31'd0, rr_ready_0}, 32'd1);
        chk("bp_drain_ready1", {31'd0, rr_ready_1}, 32'd0);
        step();

        // Idle drive: responses hold for three cycles.
        set_req0(1'b0, 4'd0, '0, '0);
        set_req1(1'b0, 4'd0, '0, '0);
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("idle_alu_op", {28'd0, rr_alu_op}, 32'hF);
            chk("idle_alu_a", rr_alu_a, 32'd0);
            chk("idle_alu_b", rr_alu_b, 32'd0);
            chk("idle_ready0", {31'd0, rr_ready_0}, 32'd0);
            chk("idle_rv0", {31'd0, rr_rv_0}, 32'd1);
            chk("idle_rd0", rr_rd_0, 32'd3);
            chk("idle_rv1", {31'd0, rr_rv_1}, 32'd0);
            chk("idle_rd1", rr_rd_1, 32'h33);
            step();
        end

        // Fixed priority starves port 1; round-robin instance alternates alongside.
        do_reset();
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;
        set_req1(1'b1, 4'd10, 32'd0, 32'd77);
        set_req0(1'b1, 4'd0, 32'd1, 32'd1);
        settle();
        chk("fp_c1_ready0", {31'd0, fp_ready_0}, 32'd1);
        chk("fp_c1_ready1", {31'd0, fp_ready_1}, 32'd0);
        chk("rr_c1_ready0", {31'd0, rr_ready_0}, 32'd1);
        step();
        set_req0(1'b1, 4'd1, 32'd9, 32'd4);
        settle();
        chk("fp_c2_rd0", fp_rd_0, 32'd2);
        chk("fp_c2_ready0", {31'd0, fp_ready_0}, 32'd1);
        chk("fp_c2_ready1", {31'd0, fp_ready_1}, 32'd0);
        chk("rr_c2_ready1", {31'd0, rr_ready_1}, 32'd1);
        step();
        set_req0(1'b1, 4'd7, 32'd1, 32'd4);
        settle();
        chk("fp_c3_rv0", {31'd0, fp_rv_0}, 32'd1);
        chk("fp_c3_rd0", fp_rd_0, 32'd5);
        chk("fp_c3_ready0", {31'd0, fp_ready_0}, 32'd1);
        chk("fp_c3_ready1", {31'd0, fp_ready_1}, 32'd0);
        chk("rr_c3_ready0", {31'd0, rr_ready_0}, 32'd1);
        chk("rr_c3_rd1", rr_rd_1, 32'd77);
        step();
        set_req0(1'b1, 4'd8, 32'h8000_0000, 32'd4);
        settle();
        chk("fp_c4_rd0", fp_rd_0, 32'd16);
        chk("fp_c4_ready0", {31'd0, fp_ready_0}, 32'd1);
        chk("fp_c4_ready1", {31'd0, fp_ready_1}, 32'd0);
        chk("rr_c4_ready1", {31'd0, rr_ready_1}, 32'd1);
        step();
        set_req0(1'b0, 4'd0, '0, '0);
        set_req1(1'b0, 4'd0, '0, '0);
        settle();
        chk("fp_sra_rd0", fp_rd_0, 32'hF800_0000);
        chk("fp_rv1_starved", {31'd0, fp_rv_1}, 32'd0);

        // Mid-operation reset discards port 1's result.
        do_reset();
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        set_req1(1'b1, 4'd6, 32'd1, 32'd2);
        settle();
        chk("mid_ready1", {31'd0, rr_ready_1}, 32'd1);
        chk("mid_alu_op", {28'd0, rr_alu_op}, 32'd6);
        step();
        set_req1(1'b0, 4'd0, '0, '0);
        settle();
        chk("mid_rv1", {31'd0, rr_rv_1}, 32'd1);
        chk("mid_rd1", rr_rd_1, 32'd1);
        rst_n = 1'b0;
        set_req0(1'b1, 4'd0, 32'd4, 32'd4);
        settle();
        chk("mid_rst_ready0", {31'd0, rr_ready_0}, 32'd0);
        chk("mid_rst_alu_a", rr_alu_a, 32'd0);
        step();
        rst_n = 1'b1;
        set_req0(1'b0, 4'd0, '0, '0);
        settle();
        chk("mid_after_rv1", {31'd0, rr_rv_1}, 32'd0);
        chk("mid_after_rd1", rr_rd_1, 32'd0);
        chk("mid_after_rv0", {31'd0, rr_rv_0}, 32'd0);
        set_req0(1'b1, 4'd0, 32'd2, 32'd2);
        set_req1(1'b1, 4'd0, 32'd3, 32'd3);
        settle();
        chk("mid_tie_ready0", {31'd0, rr_ready_0}, 32'd1);
        chk("mid_tie_ready1", {31'd0, rr_ready_1}, 32'd0);
        step();
        set_req0(1'b0, 4'd0, '0, '0);
        set_req1(1'b0, 4'd0, '0, '0);
        settle();
        chk("mid_tie_rd0", rr_rd_0, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and response buffer that time-shares the single 32-bit ALU between the execute-stage requester (port 0) and an auxiliary requester (port 1, e.g. branch-target or CSR unit). Each port issues operand/opcode requests over a valid/ready handshake. The block grants at most one request per cycle, drives the shared ALU's A/B/ALUop inputs combinationally from the winner, and captures the ALU result into that port's one-entry response register. Results return to the requester with a one-cycle latency and respect per-port backpressure.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `FIXED_PRIO`, 0, arbitration mode: 0 = round-robin; 1 = port 0 always wins ties.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid_0`, `req_valid_1`  in  1 each  request present.
- `req_ready_0`, `req_ready_1`  out  1 each  request accepted this cycle (grant).
- `req_a_0`, `req_b_0`, `req_a_1`, `req_b_1`  in  WIDTH each  operands.
- `req_op_0`, `req_op_1`  in  4 each  ALUop encoding (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRA 1000, SRL 1001, COPY_B 1010, XXX 1111).
- `alu_a`, `alu_b`  out  WIDTH each  to shared ALU A/B.
- `alu_op`  out  4  to shared ALU ALUop.
- `alu_out`  in  WIDTH  from shared ALU Out (combinational).
- `resp_valid_0`, `resp_valid_1`  out  1 each  response register full.
- `resp_data_0`, `resp_data_1`  out  WIDTH each  result.
- `resp_ready_0`, `resp_ready_1`  in  1 each  requester consumes response.

## Operation
- Eligibility: port i is eligible when `req_valid_i` is high and either `resp_valid_i`=0 or `resp_ready_i`=1 in the same cycle. Drain and refill in one cycle are allowed.
- Arbitration:
  - Only one port eligible: that port wins.
  - Both eligible, `FIXED_PRIO`=1: port 0 wins.
  - Both eligible, `FIXED_PRIO`=0: the port not in `last_grant` wins.
  - `last_grant` updates only on an actual grant.
- `req_ready_i` = grant_i. This is combinational from the valids, resp state and resp_ready, and is never high for both ports. A transfer occurs when valid and ready are both high.
- Requesters hold `req_a/b/op` stable while valid and not ready. The block does not check this.
- ALU drive:
  - Granted cycle: `alu_a`/`alu_b`/`alu_op` are the winner's `req_a`/`req_b`/`req_op`.
  - No grant: `alu_a`=0, `alu_b`=0, `alu_op`=1111 (XXX).
- Response register, per port, on each edge:
  - Granted: `resp_data_i`<=`alu_out`, `resp_valid_i`<=1.
  - Else if `resp_valid_i` and `resp_ready_i`: `resp_valid_i`<=0, and `resp_data_i` holds its last value.
  - Else: hold.
- Opcodes are passed through unmodified. Undefined opcodes return whatever the ALU produces (0).

## Timing
- Reset (`rst_n`=0 at an edge):
  - `resp_valid_0/1`=0 and `resp_data_0/1`=0.
  - `last_grant`=1, so port 0 wins the first tie.
  - While `rst_n`=0, `req_ready_0/1`=0 and the ALU inputs are forced to the idle values.
- Reset mid-operation: any buffered, unconsumed response is discarded. A request presented during the reset cycle is not accepted.
- Latency: request accepted at edge N; `resp_valid_i`=1 with data from edge N visible in cycle N+1.
- Throughput: one grant per cycle total. Each port sustains one result per cycle if its `resp_ready` stays high.
- Round-robin guarantees: with both ports continuously eligible, grants alternate 0,1,0,1... Neither port waits more than one cycle when both are eligible.
- `FIXED_PRIO`=1: port 1 can starve indefinitely. This is acceptable by design.
- Backpressure: a port whose response is full and not being drained gets `req_ready`=0. The other port may be granted in that cycle.
- Simultaneous grant and drain on the same port: the new result overwrites and `resp_valid` stays 1.

## Test plan
- Single op: reset; port 0 sends ADD, A=5, B=7 -> `req_ready_0`=1 same cycle, `alu_op`=0000; next cycle `resp_valid_0`=1, `resp_data_0`=12.
- Tie after reset: both valid in the same cycle (port 0 SUB 10,3; port 1 XOR 0xF0,0xFF) -> cycle 1 grants port 0 (resp 7), cycle 2 grants port 1 (resp 0x0F). With both held valid thereafter, grants alternate.
- Backpressure: `resp_valid_0`=1, `resp_ready_0`=0, both requesting -> `req_ready_0`=0 and port 1 granted. Raising `resp_ready_0` makes port 0 eligible in that same cycle.
- Idle drive: no requests for 3 cycles -> `alu_op`=1111, `alu_a`=`alu_b`=0, responses hold their values.
- Fixed priority: `FIXED_PRIO`=1, both continuously valid for 4 cycles -> port 0 granted every cycle, `req_ready_1`=0 throughout.
- Mid-op reset: port 1 SLTU A=1, B=2 accepted, then `rst_n`=0 before consume -> `resp_valid_1`=0, `resp_data_1`=0 after reset. The next tie grants port 0.
